// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a DIGITS-wide
// seven-segment display. Holds DIGITS hex nibbles, accepts key bytes over a
// valid/ready handshake into a one-entry pending register, and commits them
// only when a digit slot ends so the lit digit never changes mid-display.
// One external hex-to-segment decoder is shared by sequencing hex_out.
//
// Optional feature: define LZ_BLANK_EN for leading-zero suppression (slots
// above digit 0 whose digit and all higher digits are zero stay dark).
module seg_scan_ctrl #(
   parameter int DIGITS    = 4,
   parameter int SHOW_CYC  = 50000,
   parameter int BLANK_CYC = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [7:0]        wr_data,
   input  logic              clr,
   output logic [3:0]        hex_out,
   input  logic [6:0]        seg_in,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] an
);

   localparam int BUF_W   = 4 * DIGITS;
   localparam int IDX_W   = $clog2(DIGITS);
   localparam int CNT_MAX = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

   typedef enum logic {BLANK, SHOW} state_t;

   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [IDX_W-1:0]  idx, idx_n;
   logic [BUF_W-1:0]  digits_q, digits_n;
   logic [7:0]        pend_byte;
   logic              commit;
   logic              accept;

   assign accept = wr_valid && wr_ready;

   // Scan sequencing: slot timing, digit index advance and commit point.
   always_comb begin
      state_n = state;
      cnt_n   = cnt + 1'b1;
      idx_n   = idx;
      commit  = 1'b0;
      unique case (state)
         BLANK: begin
            if (cnt == BLANK_LAST) begin
               state_n = SHOW;
               cnt_n   = '0;
            end
         end
         SHOW: begin
            if (cnt == SHOW_LAST) begin
               state_n = BLANK;
               cnt_n   = '0;
               idx_n   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
               // a byte is pending exactly when wr_ready is low
               commit  = !wr_ready;
            end
         end
         default: ;
      endcase
   end

   // Next digit buffer: clear first, then shift in the committed byte.
   always_comb begin
      digits_n = clr ? '0 : digits_q;
      if (commit) begin
         digits_n = (digits_n << 8) | BUF_W'(pend_byte);
      end
   end

`ifdef LZ_BLANK_EN
   logic suppress;
   logic upper_zero;

   // True when the current digit and every digit above it are zero.
   always_comb begin
      upper_zero = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (i >= int'(idx) && digits_n[4*i +: 4] != 4'h0) begin
            upper_zero = 1'b0;
         end
      end
   end

   // Decide once per slot, on SHOW entry, whether this slot stays dark.
   always_ff @(posedge clk) begin
      if (rst) begin
         suppress <= 1'b0;
      end else if (state == BLANK && state_n == SHOW) begin
         suppress <= (idx != '0) && upper_zero;
      end
   end

   // Anode drive: only the indexed digit during SHOW, unless suppressed.
   always_comb begin
      an = '1;
      if (state == SHOW && !suppress) begin
         an = ~(DIGITS'(1) << idx);
      end
   end
`else
   // Anode drive: only the indexed digit during SHOW.
   always_comb begin
      an = '1;
      if (state == SHOW) begin
         an = ~(DIGITS'(1) << idx);
      end
   end
`endif

   // Pending byte capture; validity is tracked by wr_ready.
   always_ff @(posedge clk) begin
      if (accept) begin
         pend_byte <= wr_data;
      end
   end

   // State, handshake, digit buffer and decoder-path registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= BLANK;
         cnt      <= '0;
         idx      <= '0;
         wr_ready <= 1'b1;
         digits_q <= '0;
         hex_out  <= 4'h0;
         seg      <= 7'h7F;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         idx      <= idx_n;
         digits_q <= digits_n;
         seg      <= seg_in;
         if (commit) begin
            wr_ready <= 1'b1;
         end else if (accept) begin
            wr_ready <= 1'b0;
         end
         // hex_out is frozen through SHOW; during BLANK it tracks the
         // upcoming digit so the decoder output settles before the anode.
         if (state_n == BLANK) begin
            hex_out <= digits_n[{idx_n, 2'b00} +: 4];
         end
      end
   end

endmodule
